mask_decoder: RTL

//   Consumer end of the mask unit's output handshake. Captures a {i_mask, w_mask, o_mask} triple,

---
 rtl/mask_decoder.sv | 99 +++++++++
 1 files changed

// File: rtl/mask_decoder.sv
// rtl/mask_decoder.sv - walks effectual o_mask bits LSB-first, emitting lane and compressed operand indices
module mask_decoder #(
  parameter int length = 32,
  parameter int IDXW   = $clog2(length)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mask_valid,
  input  logic [length-1:0] i_mask,
  input  logic [length-1:0] w_mask,
  input  logic [length-1:0] o_mask,
  output logic              mask_taken,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDXW-1:0]   pos,
  output logic [IDXW-1:0]   i_idx,
  output logic [IDXW-1:0]   w_idx,
  output logic              last,
  output logic [IDXW:0]     pair_count,
  output logic              done,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, DONE = 2'b10} state_t;

  localparam logic [length-1:0] ONE = {{(length-1){1'b0}}, 1'b1};

  state_t            cur, nxt;
  logic [length-1:0] i_mask_r, w_mask_r, o_mask_r, r;
  logic [IDXW-1:0]   p;
  logic [length-1:0] lower;
  logic [IDXW:0]     i_cnt, w_cnt;
  logic              r_single;
  logic              capture, handshake;

  function automatic logic [IDXW:0] popcnt(input logic [length-1:0] v);
    logic [IDXW:0] c;
    c = '0;
    for (int k = 0; k < length; k++) c = c + {{IDXW{1'b0}}, v[k]};
    return c;
  endfunction

  // Lowest set bit of the remaining work; lanes below it select the bits to count.
  always_comb begin
    p = '0;
    for (int k = length - 1; k >= 0; k--)
      if (r[k]) p = k[IDXW-1:0];
    lower = '0;
    for (int k = 0; k < length; k++) lower[k] = (k < int'(p));
  end

  assign i_cnt      = popcnt(i_mask_r & lower);
  assign w_cnt      = popcnt(w_mask_r & lower);
  assign r_single   = (r != '0) && ((r & (r - ONE)) == '0);
  assign capture    = (cur == IDLE) && mask_valid;
  assign handshake  = idx_valid && idx_ready;

  assign idx_valid  = (cur == SCAN);
  assign done       = (cur == DONE);
  assign last       = idx_valid && r_single;
  assign pos        = p;
  assign i_idx      = i_cnt[IDXW-1:0];
  assign w_idx      = w_cnt[IDXW-1:0];
  assign pair_count = popcnt(o_mask_r);
  assign state      = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= IDLE;
      i_mask_r   <= '0;
      w_mask_r   <= '0;
      o_mask_r   <= '0;
      r          <= '0;
      mask_taken <= 1'b0;
    end else begin
      cur        <= nxt;
      mask_taken <= capture;
      if (capture) begin
        i_mask_r <= i_mask;
        w_mask_r <= w_mask;
        o_mask_r <= o_mask;
        r        <= o_mask;
      end else if (handshake) begin
        r <= r & ~(ONE << p);
      end
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (mask_valid) nxt = (o_mask != '0) ? SCAN : DONE;
      SCAN:    if (handshake && r_single) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

endmodule
